// File: rtl/mac_gen_pkg.sv
// Shared constants, enums and byte-level helper functions for the Ethernet
// frame generator.
package mac_gen_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam int          PREAMBLE_BYTES = 7;
  localparam int          DA_OFFSET      = 8;   // first destination byte (after SFD)
  localparam int          HDR_BYTES      = 22;  // preamble+SFD+DA+SA+length
  localparam int          MIN_PAYLOAD    = 46;
  localparam int          FCS_BYTES      = 4;
  localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [7:0]  PRBS_DEFAULT   = 8'hFF;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_INCR  = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_RSVD  = 2'd3   // behaves as MODE_FIXED
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_IFG   = 2'd2
  } state_e;

  // Reflected CRC-32 update by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // PRBS8 state after eight shifts; the result is also the emitted byte.
  function automatic logic [7:0] prbs8_byte(input logic [7:0] s);
    logic [7:0] v;
    v = s;
    for (int b = 0; b < 8; b++) begin
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    end
    return v;
  endfunction

endpackage

// File: rtl/mac_crc32_multi.sv
// Combinational CRC-32 update over up to DATA_BYTES lanes; only lanes whose
// enable bit is set are folded in, in wire order (lane 0 first).
module mac_crc32_multi
  import mac_gen_pkg::*;
#(
  parameter int DATA_BYTES = 8
) (
  input  logic [31:0]             crc_in,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   enable,
  output logic [31:0]             crc_out
);

  // Fold each enabled lane into the running CRC.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    crc_out = crc_in;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (enable[i]) begin
        crc_out = crc32_byte(crc_out, data[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/mac_frame_streamer.sv
// Streaming Ethernet frame generator: preamble/SFD, DA, SA, length, payload,
// zero pad and FCS emitted as a DATA_BYTES-wide valid/ready stream, followed
// by an enforced inter-frame gap. Lane content is a pure function of the byte
// index and the fields latched at start, so stalls never disturb the beat.
module mac_frame_streamer
  import mac_gen_pkg::*;
#(
  parameter int         DATA_BYTES           = 8,
  parameter int         PAYLOAD_MAX_SIZE     = 1500,
  parameter logic [7:0] PAYLOAD_CHAR_PATTERN = 8'h55,
  parameter int         MIN_IFG_CYCLES       = 3
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [47:0]             i_dest_address,
  input  logic [47:0]             i_src_address,
  input  logic [15:0]             i_payload_length,
  input  logic [1:0]              i_mode,
  input  logic [7:0]              i_prbs_seed,
  input  logic                    i_prbs_reload,
  input  logic                    i_ready,
  output logic [8*DATA_BYTES-1:0] o_data,
  output logic [DATA_BYTES-1:0]   o_keep,
  output logic                    o_valid,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [31:0]             o_frame_count
);

  localparam int               IFG_W      = (MIN_IFG_CYCLES > 1) ? $clog2(MIN_IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0] IFG_LAST   = IFG_W'((MIN_IFG_CYCLES > 0) ? MIN_IFG_CYCLES - 1 : 0);
  localparam logic [15:0]      BEAT_BYTES = 16'(DATA_BYTES);
  localparam logic [15:0]      MAX_LEN    = 16'(PAYLOAD_MAX_SIZE);

  state_e                  state_q, state_d;
  logic [IFG_W-1:0]        ifg_q;
  logic [47:0]             dest_q, src_q;
  logic [15:0]             len_q;
  mode_e                   mode_q;
  logic [15:0]             byte_index;
  logic [31:0]             crc_q, crc_next;
  logic [7:0]              prbs_q, prbs_next;
  logic                    done_q;
  logic [31:0]             count_q;

  logic                    accept, fire, last_beat;
  logic [15:0]             pay_end, pad_end, total_len;
  logic [7:0]              hdr [32];
  logic [8*DATA_BYTES-1:0] raw_data, beat_data;
  logic [DATA_BYTES-1:0]   crc_en, fcs_lane, lane_keep;
  logic [1:0]              fcs_idx [DATA_BYTES];
  logic [31:0]             fcs;

  assign accept    = (state_q == ST_IDLE) && i_start;
  assign fire      = o_valid && i_ready;
  assign pay_end   = 16'(HDR_BYTES) + len_q;
  assign pad_end   = 16'(HDR_BYTES) + ((len_q > 16'(MIN_PAYLOAD)) ? len_q : 16'(MIN_PAYLOAD));
  assign total_len = pad_end + 16'(FCS_BYTES);
  assign last_beat = (byte_index + BEAT_BYTES) >= total_len;
  assign fcs       = ~crc_next;

  // FSM state register.
  always_ff @(posedge clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: idle -> frame on start, frame -> gap after last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_FRAME;
      ST_FRAME: if (fire && last_beat) state_d = (MIN_IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
      ST_IFG:   if (ifg_q == IFG_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Inter-frame gap cycle counter, cleared outside the gap.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)                   ifg_q <= '0;
    else if (state_q == ST_IFG)  ifg_q <= ifg_q + IFG_W'(1);
    else                         ifg_q <= '0;
  end

  // Latch frame fields on start; advance byte index and CRC per transfer.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      dest_q     <= '0;
      src_q      <= '0;
      len_q      <= '0;
      mode_q     <= MODE_FIXED;
      byte_index <= '0;
      crc_q      <= CRC_INIT;
    end else if (accept) begin
      dest_q     <= i_dest_address;
      src_q      <= i_src_address;
      len_q      <= (i_payload_length > MAX_LEN) ? MAX_LEN : i_payload_length;
      mode_q     <= mode_e'(i_mode);
      byte_index <= '0;
      crc_q      <= CRC_INIT;
    end else if (fire) begin
      byte_index <= byte_index + BEAT_BYTES;
      crc_q      <= crc_next;
    end
  end

  // PRBS state: reload only while idle (seed 0 would lock up, so use FF);
  // otherwise advance by however many PRBS bytes the transferred beat used.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      prbs_q <= PRBS_DEFAULT;
    end else if ((state_q == ST_IDLE) && i_prbs_reload) begin
      prbs_q <= (i_prbs_seed == 8'h00) ? PRBS_DEFAULT : i_prbs_seed;
    end else if (fire) begin
      prbs_q <= prbs_next;
    end
  end

  // Completion pulse and wrapping frame counter, one cycle after the last transfer.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= fire && last_beat;
      if (fire && last_beat) count_q <= count_q + 32'd1;
    end
  end

  // Fixed header bytes indexed by wire position (entries past 21 unused).
  always_comb begin
    for (int i = 0; i < 32; i++) hdr[i] = 8'h00;
    for (int i = 0; i < PREAMBLE_BYTES; i++) hdr[i] = PREAMBLE_BYTE;
    hdr[PREAMBLE_BYTES] = SFD_BYTE;
    for (int i = 0; i < 6; i++) begin
      hdr[DA_OFFSET + i]     = dest_q[8*(5-i) +: 8];
      hdr[DA_OFFSET + 6 + i] = src_q[8*(5-i) +: 8];
    end
    hdr[HDR_BYTES-2] = len_q[15:8];
    hdr[HDR_BYTES-1] = len_q[7:0];
  end

  // Per-lane content for the current beat (FCS lanes resolved later), plus
  // CRC coverage, FCS position and keep masks. The PRBS chain steps once per
  // payload lane so a beat may hold several consecutive PRBS bytes.
  always_comb begin
    logic [15:0] idx;
    logic [7:0]  chain;
    idx       = '0;
    chain     = prbs_q;
    raw_data  = '0;
    crc_en    = '0;
    fcs_lane  = '0;
    lane_keep = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      fcs_idx[i] = 2'd0;
      idx = byte_index + 16'(i);
      if (idx < 16'(HDR_BYTES)) begin
        raw_data[8*i +: 8] = hdr[idx[4:0]];
      end else if (idx < pay_end) begin
        case (mode_q)
          MODE_INCR: raw_data[8*i +: 8] = 8'(idx - 16'(HDR_BYTES));
          MODE_PRBS: begin
            chain              = prbs8_byte(chain);
            raw_data[8*i +: 8] = chain;
          end
          default:   raw_data[8*i +: 8] = PAYLOAD_CHAR_PATTERN;
        endcase
      end
      crc_en[i]    = (idx >= 16'(DA_OFFSET)) && (idx < pad_end);
      fcs_lane[i]  = (idx >= pad_end) && (idx < total_len);
      fcs_idx[i]   = 2'(idx - pad_end);
      lane_keep[i] = idx < total_len;
    end
    prbs_next = chain;
  end

  mac_crc32_multi #(
    .DATA_BYTES (DATA_BYTES)
  ) u_crc (
    .crc_in  (crc_q),
    .data    (raw_data),
    .enable  (crc_en),
    .crc_out (crc_next)
  );

  // Splice FCS bytes (LSB first) into lanes following the CRC-covered ones.
  always_comb begin
    beat_data = raw_data;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (fcs_lane[i]) beat_data[8*i +: 8] = fcs[{fcs_idx[i], 3'b000} +: 8];
    end
  end

  assign o_valid       = (state_q == ST_FRAME);
  assign o_data        = o_valid ? beat_data : '0;
  assign o_keep        = o_valid ? lane_keep : '0;
  assign o_last        = o_valid && last_beat;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_frame_count = count_q;

endmodule

// File: tb/tb_mac_frame_streamer.sv
// Self-checking bench for mac_frame_streamer: a byte-queue frame model built
// from the frame rules is compared against the captured beat stream.
module tb_mac_frame_streamer;

  localparam int         DB   = 8;
  localparam int         PMAX = 1500;
  localparam logic [7:0] PAT  = 8'h55;
  localparam int         IFG  = 3;

  logic          clk, i_rst, i_start, i_prbs_reload, i_ready;
  logic [47:0]   i_dest_address, i_src_address;
  logic [15:0]   i_payload_length;
  logic [1:0]    i_mode;
  logic [7:0]    i_prbs_seed;
  logic [8*DB-1:0] o_data;
  logic [DB-1:0] o_keep;
  logic          o_valid, o_last, o_busy, o_done;
  logic [31:0]   o_frame_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [7:0] model_prbs = 8'hFF;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_beats;
  logic [DB-1:0]   got_last_keep;
  logic [8*DB-1:0] got_first;

  mac_frame_streamer #(
    .DATA_BYTES           (DB),
    .PAYLOAD_MAX_SIZE     (PMAX),
    .PAYLOAD_CHAR_PATTERN (PAT),
    .MIN_IFG_CYCLES       (IFG)
  ) dut (
    .clk              (clk),
    .i_rst            (i_rst),
    .i_start          (i_start),
    .i_dest_address   (i_dest_address),
    .i_src_address    (i_src_address),
    .i_payload_length (i_payload_length),
    .i_mode           (i_mode),
    .i_prbs_seed      (i_prbs_seed),
    .i_prbs_reload    (i_prbs_reload),
    .i_ready          (i_ready),
    .o_data           (o_data),
    .o_keep           (o_keep),
    .o_valid          (o_valid),
    .o_last           (o_last),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_frame_count    (o_frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Eight PRBS8 shifts, as the payload rule defines them.
  function automatic logic [7:0] prbs_step(input logic [7:0] s);
    logic [7:0] v;
    v = s;
    repeat (8) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  // Bit-serial reflected CRC-32 over exp_q[from..upto-1], complemented.
  function automatic logic [31:0] model_fcs(input int from, input int upto);
    logic [31:0] crc;
    logic [7:0]  b;
    crc = 32'hFFFF_FFFF;
    for (int i = from; i < upto; i++) begin
      b = exp_q[i];
      for (int k = 0; k < 8; k++) begin
        if (crc[0] ^ b[k]) crc = (crc >> 1) ^ 32'hEDB88320;
        else               crc = crc >> 1;
      end
    end
    return ~crc;
  endfunction

  task automatic model_frame(input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] req, input logic [1:0] mode);
    logic [15:0] len;
    logic [31:0] f;
    len = (req > 16'(PMAX)) ? 16'(PMAX) : req;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) exp_q.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(s[47-8*i -: 8]);
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[7:0]);
    for (int k = 0; k < int'(len); k++) begin
      if (mode == 2'd1) exp_q.push_back(8'(k));
      else if (mode == 2'd2) begin
        model_prbs = prbs_step(model_prbs);
        exp_q.push_back(model_prbs);
      end else exp_q.push_back(PAT);
    end
    for (int k = int'(len); k < 46; k++) exp_q.push_back(8'h00);
    f = model_fcs(8, exp_q.size());
    for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
  endtask

  task automatic start_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] len,
                             input logic [1:0] mode, input bit reload, input logic [7:0] seed);
    @(negedge clk);
    i_dest_address   = d;
    i_src_address    = s;
    i_payload_length = len;
    i_mode           = mode;
    i_prbs_seed      = seed;
    i_prbs_reload    = reload;
    i_start          = 1'b1;
  endtask

  // Capture one frame; disturb 1 = stray start mid-frame, 2 = reload mid-frame.
  task automatic collect(input string tag, input int ready_pct, input int disturb);
    int budget, bad_stall, bad_keep;
    bit held, finished;
    logic [8*DB-1:0] pdata;
    logic [DB-1:0]   pkeep;
    logic            plast;
    got_q.delete();
    got_beats = 0; budget = 0; bad_stall = 0; bad_keep = 0;
    held = 0; finished = 0; pdata = '0; pkeep = '0; plast = 0;
    while (!finished && budget < 5000) begin
      @(negedge clk);
      budget++;
      i_start = 1'b0;
      i_prbs_reload = 1'b0;
      if (budget == 1) begin
        check({tag, "/first_valid"}, 64'(o_valid), 64'd1);
        check({tag, "/busy_rise"}, 64'(o_busy), 64'd1);
      end
      if (disturb == 1 && budget == 6) begin
        i_start = 1'b1; i_payload_length = 16'd10; i_mode = 2'd1;
      end
      if (disturb == 2 && budget == 6) begin
        i_prbs_reload = 1'b1; i_prbs_seed = 8'h12;
      end
      if (held && !(o_data === pdata && o_keep === pkeep && o_last === plast)) bad_stall++;
      if (o_valid !== 1'b1) bad_stall++;
      i_ready = ($urandom_range(99) < ready_pct);
      if (o_valid && i_ready) begin
        if (got_beats == 0) got_first = o_data;
        got_beats++;
        for (int i = 0; i < DB; i++) if (o_keep[i]) got_q.push_back(o_data[8*i +: 8]);
        if (o_last) begin
          finished = 1;
          got_last_keep = o_keep;
        end else if (o_keep !== '1) bad_keep++;
      end
      held = o_valid && !i_ready;
      pdata = o_data; pkeep = o_keep; plast = o_last;
    end
    check({tag, "/completed"}, 64'(finished), 64'd1);
    check({tag, "/stall_stability"}, 64'(bad_stall), 64'd0);
    check({tag, "/mid_keep_full"}, 64'(bad_keep), 64'd0);
  endtask

  task automatic compare(input string tag);
    int t, mism, first_bad;
    logic [DB-1:0]   keep_exp;
    logic [8*DB-1:0] first_exp;
    t = exp_q.size();
    check({tag, "/byte_count"}, 64'(got_q.size()), 64'(t));
    mism = 0; first_bad = -1;
    for (int i = 0; i < t && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    end
    check({tag, "/byte_mismatches"}, 64'(mism), 64'd0);
    if (first_bad >= 0)
      check($sformatf("%s/byte%0d", tag, first_bad), 64'(got_q[first_bad]), 64'(exp_q[first_bad]));
    check({tag, "/beats"}, 64'(got_beats), 64'((t + DB - 1) / DB));
    keep_exp = (t % DB == 0) ? '1 : DB'((1 << (t % DB)) - 1);
    check({tag, "/last_keep"}, 64'(got_last_keep), 64'(keep_exp));
    for (int i = 0; i < DB; i++) first_exp[8*i +: 8] = exp_q[i];
    check({tag, "/first_beat"}, 64'(got_first), 64'(first_exp));
  endtask

  task automatic post_frame(input string tag);
    int busy_cycles, done_pulses;
    @(negedge clk);
    exp_count++;
    check({tag, "/done"}, 64'(o_done), 64'd1);
    check({tag, "/frame_count"}, 64'(o_frame_count), 64'(exp_count));
    busy_cycles = 0; done_pulses = 0;
    while (o_busy && busy_cycles < 50) begin
      busy_cycles++;
      if (o_done) done_pulses++;
      @(negedge clk);
    end
    check({tag, "/ifg_busy_cycles"}, 64'(busy_cycles), 64'(IFG));
    check({tag, "/done_pulses"}, 64'(done_pulses), 64'd1);
    @(negedge clk);
    check({tag, "/idle_after"}, 64'({o_valid, o_busy}), 64'd0);
  endtask

  task automatic run_frame(input string tag, input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] len, input logic [1:0] mode, input int ready_pct,
                           input int disturb, input bit reload, input logic [7:0] seed);
    if (reload) model_prbs = (seed == 8'h00) ? 8'hFF : seed;
    model_frame(d, s, len, mode);
    start_frame(d, s, len, mode, reload, seed);
    collect(tag, ready_pct, disturb);
    compare(tag);
    post_frame(tag);
  endtask

  initial begin
    logic [7:0]  first_pay[8];
    logic [63:0] r64a, r64b;
    int          pay_bad;
    int          blen[4] = '{0, 45, 46, 47};

    i_rst = 1'b1; i_start = 1'b0; i_prbs_reload = 1'b0; i_ready = 1'b1;
    i_dest_address = '0; i_src_address = '0; i_payload_length = '0;
    i_mode = '0; i_prbs_seed = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset/valid", 64'(o_valid), 64'd0);
    check("reset/last", 64'(o_last), 64'd0);
    check("reset/done", 64'(o_done), 64'd0);
    check("reset/busy", 64'(o_busy), 64'd0);
    check("reset/data", 64'(o_data), 64'd0);
    check("reset/keep", 64'(o_keep), 64'd0);
    check("reset/count", 64'(o_frame_count), 64'd0);
    i_rst = 1'b0;

    // Plan 1: fixed pattern, L=64, broadcast DA.
    run_frame("t1", 48'hFFFF_FFFF_FFFF, 48'h1122_3344_5566, 16'd64, 2'd0, 100, 0, 0, 8'h00);
    // Plan 2: incrementing payload, L=8 -> 38 pad bytes.
    run_frame("t2", 48'h0102_0304_0506, 48'hA1A2_A3A4_A5A6, 16'd8, 2'd1, 100, 0, 0, 8'h00);

    // Plan 3: PRBS continuity, reload ignored while busy, reload+start together.
    @(negedge clk);
    i_prbs_reload = 1'b1; i_prbs_seed = 8'hFF;
    model_prbs = 8'hFF;
    @(negedge clk);
    i_prbs_reload = 1'b0;
    run_frame("t3a", 48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 16'd64, 2'd2, 100, 0, 0, 8'h00);
    for (int k = 0; k < 8; k++) first_pay[k] = got_q[22 + k];
    run_frame("t3b", 48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 16'd128, 2'd2, 100, 2, 0, 8'h00);
    run_frame("t3c", 48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 16'd8, 2'd2, 100, 0, 1, 8'h00);
    pay_bad = 0;
    for (int k = 0; k < 8; k++) if (got_q[22 + k] !== first_pay[k]) pay_bad++;
    check("t3c/prbs_restart_matches", 64'(pay_bad), 64'd0);

    // Plan 4: backpressure, then random frames incl. pad boundaries and mode 3.
    run_frame("t4_bp", 48'hFFFF_FFFF_FFFF, 48'h1122_3344_5566, 16'd64, 2'd0, 50, 0, 0, 8'h00);
    for (int n = 0; n < 8; n++) begin
      r64a = {$urandom, $urandom};
      r64b = {$urandom, $urandom};
      run_frame($sformatf("t4_rnd%0d", n), r64a[47:0], r64b[47:0],
                (n < 4) ? 16'(blen[n]) : 16'($urandom_range(0, 200)),
                2'($urandom_range(0, 3)), 50, 0, 0, 8'h00);
    end

    // Plan 5: oversize request clamped, stray start mid-frame ignored.
    run_frame("t5", 48'h0000_0000_0001, 48'h0000_0000_0002, 16'd2000, 2'd1, 100, 1, 0, 8'h00);
    check("t5/total_bytes", 64'(got_q.size()), 64'd1526);

    // Plan 6: reset mid-payload, then a clean frame (PRBS back to FF).
    start_frame(48'h1111_1111_1111, 48'h2222_2222_2222, 16'd100, 2'd2, 0, 8'h00);
    i_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    check("t6/mid_valid", 64'(o_valid), 64'd1);
    i_rst = 1'b1;
    #1;
    check("t6/rst_valid", 64'(o_valid), 64'd0);
    check("t6/rst_count", 64'(o_frame_count), 64'd0);
    check("t6/rst_busy", 64'(o_busy), 64'd0);
    check("t6/rst_data_keep_last", 64'({o_data, o_keep, o_last}), 64'd0);
    @(negedge clk);
    i_rst = 1'b0;
    exp_count = 0;
    model_prbs = 8'hFF;
    run_frame("t6_after", 48'h1111_1111_1111, 48'h2222_2222_2222, 16'd20, 2'd2, 100, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_frame_streamer.md
# mac_frame_streamer

Parametrised streaming Ethernet frame generator. It builds a complete frame from latched header fields and an internally generated payload: preamble/SFD, destination, source, length, payload, zero pad and CRC-32 FCS. The frame is emitted as a DATA_BYTES-wide valid/ready byte stream rather than one flat register. It sits between test-traffic control and the MII/BASE-R encoder path, and adds backpressure, minimum-size padding, FCS, inter-frame gap and frame counting.

## Interface
- DATA_BYTES, 8: bytes per beat; supported values are 1, 2, 4 and 8.
- PAYLOAD_MAX_SIZE, 1500: largest payload length; longer requests are clamped to this value.
- PAYLOAD_CHAR_PATTERN, 8'h55: payload byte used in fixed-pattern mode.
- MIN_IFG_CYCLES, 3: idle cycles enforced after each frame; 0 is allowed.

Ports:
- clk, in, 1: single clock; all logic is rising-edge.
- i_rst, in, 1: asynchronous, active-high reset.
- i_start, in, 1: frame request; accepted only when o_busy=0.
- i_dest_address, in, 48: destination MAC; byte [47:40] goes on the wire first.
- i_src_address, in, 48: source MAC; same byte order as destination.
- i_payload_length, in, 16: payload byte count.
- i_mode, in, 2: payload mode. 0 = fixed pattern, 1 = incrementing, 2 = PRBS8, 3 = treated as 0.
- i_prbs_seed, in, 8: PRBS8 reload value.
- i_prbs_reload, in, 1: loads the seed into the PRBS state; acts only while idle.
- i_ready, in, 1: downstream ready.
- o_data, out, 8*DATA_BYTES: beat data; lane 0 (bits [7:0]) is the earliest byte on the wire.
- o_keep, out, DATA_BYTES: lane-valid mask; contiguous from lane 0.
- o_valid, out, 1: beat valid.
- o_last, out, 1: marks the final beat of a frame.
- o_busy, out, 1: high from start acceptance until the end of the IFG.
- o_done, out, 1: single-cycle pulse at the end of each frame.
- o_frame_count, out, 32: count of completed frames; wraps.

## Operation
- i_start is sampled when o_busy=0. On acceptance the block latches the addresses, mode and L = min(i_payload_length, PAYLOAD_MAX_SIZE).
- Frame byte order:
  - 7 × 0x55 preamble, then 0xD5 SFD.
  - Destination (6 bytes), source (6 bytes).
  - Length field = L[15:8], then L[7:0].
  - L payload bytes.
  - Zero pad, max(0, 46−L) bytes.
  - FCS, 4 bytes.
- Total frame bytes T = 26 + max(L, 46).
- FCS:
  - Standard CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Covers destination through pad.
  - The final value is complemented and sent least-significant byte first.
  - FCS bytes may share a beat with payload or pad; the CRC covers only the lanes before them.
- Payload modes:
  - Mode 0: every byte = PAYLOAD_CHAR_PATTERN.
  - Mode 1: byte k = k[7:0].
  - Mode 2 (PRBS8):
    - Per bit: fb = s[7]^s[5]^s[4]^s[3], then s = {s[6:0], fb}.
    - Each payload byte is the state after 8 shifts.
    - The PRBS state persists across frames.
    - Reset sets s = 8'hFF; reload sets s = i_prbs_seed, or 8'hFF if the seed is 0.
- States:
  - IDLE → FRAME on start.
  - FRAME → IFG after the last beat transfers; goes straight to IDLE if MIN_IFG_CYCLES=0.
  - IFG → IDLE after MIN_IFG_CYCLES cycles.
- The byte index advances by DATA_BYTES per transferred beat. Lane content is a pure function of byte index and latched fields.

## Timing
- Reset values:
  - o_valid, o_last, o_done, o_busy = 0.
  - o_data, o_keep, o_frame_count = 0.
  - PRBS state = 8'hFF.
  - State = IDLE.
- Latency:
  - o_busy rises and the first beat is valid on the cycle after i_start is accepted.
  - The frame takes ceil(T/DATA_BYTES) beats.
- Handshake:
  - A beat transfers when o_valid && i_ready.
  - While o_valid && !i_ready, o_data, o_keep and o_last hold stable.
  - o_valid never drops mid-frame.
- Last beat: o_keep = (1 << (T mod DATA_BYTES)) − 1, or all ones when the remainder is 0.
- o_done and the o_frame_count increment occur on the cycle after the last transfer.
- i_start while busy is ignored with no queuing. i_prbs_reload while busy is ignored.
- i_start and i_prbs_reload in the same idle cycle: the reload takes effect first, so the frame uses the new seed.
- Reset asserted mid-frame: the frame is abandoned and all outputs take reset values immediately.

## Structure
- Package mac_gen_pkg holds:
  - PREAMBLE_BYTE, SFD_BYTE, HDR_BYTES=22, MIN_PAYLOAD=46, FCS_BYTES=4, CRC_POLY.
  - mode_e and state_e enums.
  - crc32_byte and prbs8_byte functions.
- Sub-module mac_crc32_multi #(DATA_BYTES) performs the combinational multi-byte CRC update with a per-lane enable mask.

## Test plan
1. DATA_BYTES=8, mode 0, L=64, dest FF:FF:FF:FF:FF:FF, src 11:22:33:44:55:66, i_ready=1 → 90 bytes in 12 beats. Beat 0 = 55×7, D5. Last keep = 0x03. FCS matches the bench CRC model. o_done pulses once; o_frame_count = 1.
2. Mode 1, L=8 → payload 00..07, length field 0x0008, 38 zero pad bytes. T = 72, giving 9 beats with last keep 0xFF.
3. Mode 2, seed FF reloaded: frames with L=64 then L=128 continue one sequence with no restart. After a reload, a frame with L=8 reproduces the first 8 payload bytes of the first frame.
4. Random i_ready backpressure (≈50%) → byte stream identical to the i_ready=1 run, and outputs stay stable during stalls.
5. L=2000 → clamped, T = 1526. An i_start pulsed mid-frame is ignored. o_busy stays high for MIN_IFG_CYCLES cycles after o_done.
6. i_rst pulsed mid-payload → o_valid=0 and o_frame_count=0 immediately. The next i_start produces a complete frame beginning with the preamble.
